uart_tx_arbiter: RTL

Round-robin arbiter that shares the UART transmit byte channel between `NumReq` independent requesters. The UART top-level instantiates it ahead of its transmit path. Each requester offers bytes with a request/acknowledge handshake. The arbiter latches the winning byte and presents it downstream with a valid/ready handshake. A requester that has won keeps ownership for a multi-byte packet until one of three things happens: it flags the last byte, it hits the burst limit, or it goes idle past a timeout. This keeps other requesters' bytes out of its frames.

---
 rtl/uart_tx_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter sharing one UART transmit byte channel between NumReq
// requesters. A requester that wins keeps ownership for a multi-byte packet
// until it flags the last byte, reaches MaxBurst bytes, or stays idle for
// LockTimeout cycles while owning the channel.
//
// Ports:
//   i_clk       system clock
//   i_rst_n     asynchronous active-low reset
//   i_enable    low: no new grants (an in-flight byte still completes)
//   i_req       per-requester byte offer, held until its o_ack bit
//   i_data      requester k byte at [k*DataLength +: DataLength]
//   i_last      offered byte ends the packet
//   o_ack       one-cycle pulse, byte of requester k captured
//   o_tx_data   byte to the UART transmitter
//   o_tx_valid  o_tx_data valid
//   i_tx_ready  transmitter accepts the byte when high with o_tx_valid
//   o_owner     current / last owner index
//   o_locked    a requester holds ownership (SEND or LOCK)
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NumReq      = 4,
   parameter int DataLength  = 8,
   parameter int MaxBurst    = 16,
   parameter int LockTimeout = 255,
   localparam int OwnerW     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_enable,
   input  logic [NumReq-1:0]            i_req,
   input  logic [NumReq*DataLength-1:0] i_data,
   input  logic [NumReq-1:0]            i_last,
   output logic [NumReq-1:0]            o_ack,
   output logic [DataLength-1:0]        o_tx_data,
   output logic                         o_tx_valid,
   input  logic                         i_tx_ready,
   output logic [OwnerW-1:0]            o_owner,
   output logic                         o_locked
);

   localparam int BurstW = $clog2(MaxBurst + 1);
   localparam int TimerW = $clog2(LockTimeout + 1);

   localparam logic [BurstW-1:0] BurstMax  = BurstW'(MaxBurst);
   // Release fires on the edge where the timer would reach LockTimeout, so
   // LOCK lasts exactly LockTimeout idle cycles.
   localparam logic [TimerW-1:0] TimerLast = TimerW'(LockTimeout - 1);
   localparam logic [NumReq-1:0] OneHot0   = NumReq'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_LOCK
   } state_t;

   state_t              state;
   logic [OwnerW-1:0]   ptr;
   logic [BurstW-1:0]   burst;
   logic [TimerW-1:0]   timer;
   logic                last_q;

   // Unpacked view of the requester bytes so selection uses a narrow index.
   logic [DataLength-1:0] req_data [NumReq];

   for (genvar g = 0; g < NumReq; g++) begin : g_unpack
      assign req_data[g] = i_data[g*DataLength +: DataLength];
   end

   // Index arithmetic modulo NumReq (NumReq need not be a power of two).
   function automatic logic [OwnerW-1:0] wrap_add(input logic [OwnerW-1:0] a,
                                                  input int b);
      int s;
      s = int'(a) + b;
      if (s >= NumReq) s = s - NumReq;
      return s[OwnerW-1:0];
   endfunction

   // First requester at or after ptr in circular order.
   logic [OwnerW-1:0] win_idx;
   logic              win_found;

   always_comb begin
      logic [OwnerW-1:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand = wrap_add(ptr, i);
         if (!win_found && i_req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         burst      <= '0;
         timer      <= '0;
         last_q     <= 1'b0;
         o_ack      <= '0;
         o_tx_data  <= '0;
         o_tx_valid <= 1'b0;
         o_owner    <= '0;
         o_locked   <= 1'b0;
      end else begin
         o_ack <= '0;
         case (state)
            ST_IDLE: begin
               if (i_enable && win_found) begin
                  o_owner    <= win_idx;
                  o_tx_data  <= req_data[win_idx];
                  last_q     <= i_last[win_idx];
                  burst      <= BurstW'(1);
                  o_ack      <= OneHot0 << win_idx;
                  o_tx_valid <= 1'b1;
                  o_locked   <= 1'b1;
                  state      <= ST_SEND;
               end
            end

            ST_SEND: begin
               // Requests are ignored here; the byte waits for the transmitter.
               if (i_tx_ready) begin
                  o_tx_valid <= 1'b0;
                  if (last_q || burst == BurstMax || !i_enable) begin
                     ptr      <= wrap_add(o_owner, 1);
                     o_locked <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     timer <= '0;
                     state <= ST_LOCK;
                  end
               end
            end

            ST_LOCK: begin
               if (!i_enable) begin
                  ptr      <= wrap_add(o_owner, 1);
                  o_locked <= 1'b0;
                  state    <= ST_IDLE;
               end else if (i_req[o_owner]) begin
                  o_tx_data  <= req_data[o_owner];
                  last_q     <= i_last[o_owner];
                  burst      <= burst + BurstW'(1);
                  o_ack      <= OneHot0 << o_owner;
                  o_tx_valid <= 1'b1;
                  state      <= ST_SEND;
               end else if (timer >= TimerLast) begin
                  ptr      <= wrap_add(o_owner, 1);
                  o_locked <= 1'b0;
                  state    <= ST_IDLE;
               end else begin
                  timer <= timer + TimerW'(1);
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
